// File: rtl/booth_operand_sequencer.sv
// Operand FIFO and serialiser that feeds a 5-bit signed Booth multiplier and returns its 10-bit product.
// Optional mul_done watchdog is enabled by defining BOOTH_SEQ_TIMEOUT_EN.
module booth_operand_sequencer #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] in_a,
  input  logic [4:0] in_b,
  output logic       mul_start,
  output logic [4:0] mul_data,
  input  logic       mul_done,
  input  logic [9:0] mul_result,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [9:0] res_data,
  output logic       res_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT_CYCLES < 1)) begin : g_param_err
      $error("booth_operand_sequencer: DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
    end
  endgenerate

  logic [9:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [2:0]    r_state;
  logic [4:0]    r_a;
  logic [4:0]    r_b;
  logic          r_res_valid;
  logic [9:0]    r_res_data;

  logic w_full;
  logic w_in_ready;
  logic w_wr;
  logic w_pop;

  // NOTE: ready depends on the registered count only, so a pop never opens a slot in the same cycle.
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_in_ready = !w_full && !rst;
  assign w_wr       = in_valid && w_in_ready;
  assign w_pop      = (r_state == S_IDLE) && (r_count != '0) && !r_res_valid;

  // NOTE: the storage array has no reset; validity is tracked entirely by count and pointers.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {in_a, in_b};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_wr && w_pop) r_count <= r_count - CW'(1);
    end
  end

`ifdef BOOTH_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_wait_cnt;
  logic          r_res_err;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
`ifdef BOOTH_SEQ_TIMEOUT_EN
      r_wait_cnt  <= '0;
      r_res_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            {r_a, r_b} <= r_mem[r_rd_ptr];
            r_state    <= S_LOAD_A;
          end
        end
        S_LOAD_A: r_state <= S_LOAD_B;
        S_LOAD_B: begin
          r_state <= S_WAIT;
`ifdef BOOTH_SEQ_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (mul_done) begin
            r_res_data  <= mul_result;
            r_res_valid <= 1'b1;
            r_state     <= S_HOLD;
`ifdef BOOTH_SEQ_TIMEOUT_EN
            r_res_err   <= 1'b0;
          end else if (r_wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            // Multiplier never answered: hand back a flagged zero product.
            r_res_data  <= '0;
            r_res_valid <= 1'b1;
            r_res_err   <= 1'b1;
            r_state     <= S_HOLD;
          end else begin
            r_wait_cnt  <= r_wait_cnt + TW'(1);
`endif
          end
        end
        S_HOLD: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign mul_start = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
  assign mul_data  = (r_state == S_LOAD_A) ? r_a : r_b;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
`ifdef BOOTH_SEQ_TIMEOUT_EN
  assign res_err   = r_res_err;
`else
  assign res_err   = 1'b0;
`endif

endmodule

// File: tb/tb_booth_operand_sequencer.sv
// Bench for booth_operand_sequencer: a behavioural Booth multiplier model plus an expected-product queue.
// Timeout behaviour is checked for whichever build (BOOTH_SEQ_TIMEOUT_EN defined or not) is compiled.
module tb_booth_operand_sequencer;
  localparam int DEPTH = 4;
  localparam int TO    = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] in_a = '0;
  logic [4:0] in_b = '0;
  logic       mul_start;
  logic [4:0] mul_data;
  logic       mul_done;
  logic [9:0] mul_result;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [9:0] res_data;
  logic       res_err;

  int n_pass  = 0;
  int n_total = 0;

  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  booth_operand_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_start(mul_start), .mul_data(mul_data),
    .mul_done(mul_done), .mul_result(mul_result), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_err(res_err)
  );

  // Signed 5x5 product truncated to the 10-bit result bus.
  function automatic logic [9:0] prod(input logic [4:0] a, input logic [4:0] b);
    int p;
    p = $signed(a) * $signed(b);
    return p[9:0];
  endfunction

  // Behavioural multiplier: takes the two start-framed words, answers after m_latency cycles.
  bit         m_respond = 1'b1;
  int         m_latency = 3;
  logic       stray_done = 1'b0;
  logic       m_done;
  logic [9:0] m_res;
  logic       m_phase;
  logic [4:0] m_a;
  logic       m_busy;
  int         m_lat;

  assign mul_done   = m_done | stray_done;
  assign mul_result = m_done ? m_res : 10'h155;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_done <= 1'b0; m_res <= '0; m_phase <= 1'b0; m_a <= '0; m_busy <= 1'b0; m_lat <= 0;
    end else begin
      m_done <= 1'b0;
      if (mul_start) begin
        if (!m_phase) begin
          m_a <= mul_data; m_phase <= 1'b1;
        end else begin
          m_phase <= 1'b0; m_busy <= m_respond; m_lat <= m_latency; m_res <= prod(m_a, mul_data);
        end
      end else if (m_busy) begin
        if (m_lat <= 1) begin m_done <= 1'b1; m_busy <= 1'b0; end
        else m_lat <= m_lat - 1;
      end
    end
  end

  task automatic wait_res_valid(input int budget);
    for (int i = 0; i < budget && res_valid !== 1'b1; i++) @(negedge clk);
  endtask

  task automatic wait_wait_state();
    for (int i = 0; i < 50 && mul_start !== 1'b1; i++) @(negedge clk);
    for (int i = 0; i < 50 && mul_start !== 1'b0; i++) @(negedge clk);
  endtask

  task automatic accept_result();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic push_one(input logic [4:0] a, input logic [4:0] b);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready_hi: got %b expected 0", in_ready);
    else n_pass++;
    n_total++;
    if ({mul_start, mul_data, res_valid, res_data, res_err} !== 18'h0)
      $display("FAIL reset_outputs: got %h expected 0", {mul_start, mul_data, res_valid, res_data, res_err});
    else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready_lo: got %b expected 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_single();
    bit seen = 1'b0;
    m_latency = 3;
    push_one(5'b10110, 5'b01101);
    @(negedge clk);
    n_total++;
    if ({mul_start, mul_data} !== {1'b1, 5'b10110})
      $display("FAIL single_load_a: got %b expected 110110", {mul_start, mul_data});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({mul_start, mul_data} !== {1'b1, 5'b01101})
      $display("FAIL single_load_b: got %b expected 101101", {mul_start, mul_data});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({mul_start, mul_data} !== {1'b0, 5'b01101})
      $display("FAIL single_wait: got %b expected 001101", {mul_start, mul_data});
    else n_pass++;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (mul_done === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    n_total++;
    if (res_valid !== 1'b1) $display("FAIL single_valid_after_done: got %b expected 1", res_valid);
    else n_pass++;
    n_total++;
    if ({res_err, res_data} !== {1'b0, 10'h37E})
      $display("FAIL single_product: got %h expected 037e", {res_err, res_data});
    else n_pass++;
    accept_result();
    n_total++;
    if (res_valid !== 1'b0) $display("FAIL single_valid_drop: got %b expected 0", res_valid);
    else n_pass++;
  endtask

  task automatic test_burst();
    logic [4:0] ba[5];
    logic [4:0] bb[5];
    int accepted = 0;
    int idx = 1;
    ba = '{5'h01, 5'h1F, 5'h10, 5'h10, 5'h07};
    bb = '{5'h01, 5'h1F, 5'h10, 5'h0F, 5'h18};
    exp_q = '{10'h001, 10'h001, 10'h100, 10'h310, 10'h3C8};
    m_latency = 2;
    res_ready = 1'b0;
    push_one(ba[0], bb[0]);
    wait_res_valid(50);
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_a = (idx < 5) ? ba[idx] : 5'h03;
      in_b = (idx < 5) ? bb[idx] : 5'h03;
      if (in_ready === 1'b1) begin accepted++; idx++; end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_total++;
    if (accepted !== DEPTH) $display("FAIL burst_accepted: got %0d expected %0d", accepted, DEPTH);
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL burst_full_ready: got %b expected 0", in_ready);
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      logic [9:0] e;
      wait_res_valid(50);
      e = exp_q.pop_front();
      n_total++;
      if (res_valid !== 1'b1 || res_data !== e)
        $display("FAIL burst_product_%0d: got v=%b d=%h expected v=1 d=%h", k, res_valid, res_data, e);
      else n_pass++;
      accept_result();
    end
  endtask

  task automatic test_backpressure();
    logic [9:0] held;
    int bad = 0;
    m_latency = 1;
    @(negedge clk);
    in_valid = 1'b1; in_a = 5'h05; in_b = 5'h1D;
    @(negedge clk);
    in_a = 5'h19; in_b = 5'h06;
    @(negedge clk);
    in_valid = 1'b0;
    wait_res_valid(50);
    held = res_data;
    n_total++;
    if (held !== 10'h3F1) $display("FAIL bp_first_product: got %h expected 3f1", held);
    else n_pass++;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== held || mul_start !== 1'b0) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL bp_stable: got %0d unstable cycles expected 0", bad);
    else n_pass++;
    accept_result();
    n_total++;
    if ({res_valid, mul_start} !== 2'b00)
      $display("FAIL bp_accept_edge: got %b expected 00", {res_valid, mul_start});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({mul_start, mul_data} !== {1'b1, 5'h19})
      $display("FAIL bp_next_start: got %b expected 111001", {mul_start, mul_data});
    else n_pass++;
    wait_res_valid(50);
    n_total++;
    if (res_data !== 10'h3D6) $display("FAIL bp_second_product: got %h expected 3d6", res_data);
    else n_pass++;
    accept_result();
  endtask

  task automatic test_stray_done();
    m_latency = 4;
    @(negedge clk);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    @(negedge clk);
    n_total++;
    if ({res_valid, mul_start} !== 2'b00)
      $display("FAIL stray_idle: got %b expected 00", {res_valid, mul_start});
    else n_pass++;
    push_one(5'h03, 5'h1B);
    @(negedge clk);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    n_total++;
    if ({res_valid, mul_start} !== 2'b01)
      $display("FAIL stray_load_a: got %b expected 01", {res_valid, mul_start});
    else n_pass++;
    wait_res_valid(50);
    n_total++;
    if (res_data !== 10'h3F1) $display("FAIL stray_product: got %h expected 3f1", res_data);
    else n_pass++;
    accept_result();
  endtask

  task automatic test_random();
    int sent = 0;
    int got = 0;
    int bad = 0;
    exp_q.delete();
    fork
      begin
        for (int c = 0; c < 2000 && sent < 24; c++) begin
          @(negedge clk);
          in_valid = ($urandom_range(0, 3) != 0);
          in_a = 5'($urandom);
          in_b = 5'($urandom);
          if (in_valid && in_ready === 1'b1) begin
            exp_q.push_back(prod(in_a, in_b));
            sent++;
          end
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        bit hold = 1'b0;
        logic [9:0] prev = '0;
        for (int c = 0; c < 3000 && got < 24; c++) begin
          @(negedge clk);
          if (hold && (res_valid !== 1'b1 || res_data !== prev)) bad++;
          m_latency = $urandom_range(1, 6);
          res_ready = $urandom_range(0, 1);
          if (res_valid === 1'b1 && res_ready) begin
            n_total++;
            if (exp_q.size() == 0) $display("FAIL rand_unexpected: got %h expected none", res_data);
            else begin
              logic [9:0] e;
              e = exp_q.pop_front();
              if (res_data !== e || res_err !== 1'b0)
                $display("FAIL rand_product_%0d: got %h err %b expected %h err 0", got, res_data, res_err, e);
              else n_pass++;
            end
            got++;
            hold = 1'b0;
          end else hold = (res_valid === 1'b1);
          prev = res_data;
        end
        res_ready = 1'b0;
      end
    join
    n_total++;
    if (got != 24) $display("FAIL rand_count: got %0d expected 24", got);
    else n_pass++;
    n_total++;
    if (bad != 0) $display("FAIL rand_stable: got %0d unstable cycles expected 0", bad);
    else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    int bad = 0;
    m_respond = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_a = 5'h02; in_b = 5'h03;
    @(negedge clk);
    in_a = 5'h04; in_b = 5'h05;
    @(negedge clk);
    in_a = 5'h06; in_b = 5'h07;
    @(negedge clk);
    in_valid = 1'b0;
    wait_wait_state();
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({in_ready, mul_start, mul_data, res_valid, res_data, res_err} !== 19'h0)
      $display("FAIL midwait_async_reset: got %h expected 0",
               {in_ready, mul_start, mul_data, res_valid, res_data, res_err});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    m_respond = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL midwait_ready_after: got %b expected 1", in_ready);
    else n_pass++;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || mul_start !== 1'b0) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL midwait_no_activity: got %0d active cycles expected 0", bad);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int bad = 0;
    m_respond = 1'b0;
    push_one(5'h0B, 5'h02);
    wait_wait_state();
`ifdef BOOTH_SEQ_TIMEOUT_EN
    for (int k = 1; k < TO; k++) begin
      @(negedge clk);
      if (res_valid !== 1'b0) bad++;
    end
    @(negedge clk);
    n_total++;
    if (bad != 0) $display("FAIL timeout_early: got %0d early cycles expected 0", bad);
    else n_pass++;
    n_total++;
    if ({res_valid, res_err, res_data} !== {1'b1, 1'b1, 10'h000})
      $display("FAIL timeout_result: got %h expected 800", {res_valid, res_err, res_data});
    else n_pass++;
    accept_result();
`else
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || res_err !== 1'b0) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL no_timeout_wait: got %0d result cycles expected 0", bad);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
    m_respond = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_stray_done();
    test_random();
    test_reset_mid_wait();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/booth_operand_sequencer.md
# booth_operand_sequencer

Upstream feeder for the 5-bit signed Booth multiplier top (ports done / MUL_result / data_in / start). It accepts signed operand pairs over a valid/ready handshake and buffers them in a small FIFO. Each pair is serialised onto the multiplier's 5-bit data_in bus as multiplicand then multiplier, framed by start. The block waits for done, then returns the 10-bit product on a valid/ready result port, so the multiplier can be driven back-to-back without testbench-style hand timing.

## Interface
- DEPTH, 4, operand FIFO entries (power of two, >= 2)
- TIMEOUT_CYCLES, 64, max cycles waited for mul_done (used only when BOOTH_SEQ_TIMEOUT_EN is defined)
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high; one clock
- in_valid  input  1  operand pair offered
- in_ready  output  1  FIFO not full
- in_a  input  5  multiplicand, two's complement
- in_b  input  5  multiplier, two's complement
- mul_start  output  1  start to multiplier
- mul_data  output  5  data_in to multiplier
- mul_done  input  1  multiplier done
- mul_result  input  10  multiplier product, signed
- res_valid  output  1  product held
- res_ready  input  1  consumer accepts product
- res_data  output  10  product
- res_err  output  1  product invalid (timeout); constant 0 when timeout is compiled out

## Operation
- FIFO
  - Write on in_valid && in_ready.
  - in_ready = (count != DEPTH).
  - Pointers wrap modulo DEPTH.
  - Simultaneous write and pop when full: the pop frees the slot, but in_ready is still 0 that cycle (no combinational ready path from the pop).
  - Simultaneous write and pop when non-full: count unchanged.
- FSM states: IDLE, LOAD_A, LOAD_B, WAIT, HOLD.
  - IDLE: if FIFO non-empty and res_valid == 0, pop the head into registers {a_q, b_q} and go to LOAD_A.
  - LOAD_A: mul_start = 1, mul_data = a_q; next LOAD_B.
  - LOAD_B: mul_start = 1, mul_data = b_q; next WAIT.
  - WAIT: mul_start = 0, mul_data = b_q (held).
    - On mul_done = 1: capture mul_result into res_data, set res_valid, clear res_err, go to HOLD.
    - mul_done is ignored in every state except WAIT.
  - HOLD: res_valid = 1 until res_ready is sampled high.
    - On that edge, res_valid drops and the FSM goes to IDLE.
    - A new pop can occur in the following cycle.
- res_data is stable while res_valid = 1.
- Arithmetic
  - No arithmetic in this block; operands and product pass through bit-exact.
  - Range checks for benches: -16 * -16 = +256 = 10'h100; -16 * 15 = -240 = 10'h310.
- Reset, asserted at any time, including mid-WAIT:
  - FIFO emptied (count = 0, pointers = 0), FSM to IDLE.
  - All outputs take their reset values; any in-flight operation is discarded.

## Timing
- Reset values:
  - in_ready = 1 (after rst releases; 0 while rst is high).
  - mul_start = 0, mul_data = 0.
  - res_valid = 0, res_data = 0, res_err = 0.
- All outputs are registered or decoded from FSM state only; there are no combinational input-to-output paths.
- Pair written at edge N with the FIFO empty and FSM idle:
  - Pop at N+1; LOAD_A during cycle N+1..N+2; LOAD_B next cycle; WAIT from N+3.
  - mul_start is high for exactly 2 cycles per operation.
- mul_done seen at edge M: res_valid is high from M+1.
- Throughput: one product per (4 + multiplier latency + consumer stall) cycles.

## Configuration
- BOOTH_SEQ_TIMEOUT_EN defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without mul_done: go to HOLD with res_valid = 1, res_err = 1, res_data = 10'h000.
- BOOTH_SEQ_TIMEOUT_EN undefined:
  - No counter is implemented.
  - WAIT is left only on mul_done or reset; res_err is tied to 0.

## Test plan
- Single pair (-10, 13), i.e. in_a = 5'b10110, in_b = 5'b01101, with the real multiplier:
  - mul_data = 10110 then 01101 with mul_start high for 2 cycles.
  - res_data = 10'h37E (-130), res_err = 0.
- Burst of DEPTH + 1 pairs with the FSM stalled (res_ready = 0 after the first result):
  - in_ready drops after DEPTH accepted writes.
  - No overwrite occurs; the 5 products come out in order: (1,1)=1, (-1,-1)=1, (-16,-16)=256, (-16,15)=-240, (7,-8)=-56.
- Backpressure: hold res_ready = 0 for 20 cycles:
  - res_valid and res_data are stable.
  - mul_start stays 0 throughout.
  - The next operation starts 1 cycle after the accepting res_ready edge.
- Reset asserted mid-WAIT with 2 pairs queued:
  - All outputs return immediately (asynchronously) to reset values.
  - After release, in_ready = 1 and no result is produced.
- Stray mul_done during IDLE and LOAD_A: ignored; no res_valid.
- With BOOTH_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES = 8, mul_done never asserted:
  - res_valid rises 8 cycles after WAIT entry, with res_err = 1 and res_data = 0.
  - Without the macro, the block stays in WAIT indefinitely.
